mptw_arbiter: RTL and testbench

MPTW_ARBITER -- requirements
Module: mptw_arbiter

---
 rtl/mpt_pkg.sv | 16 +
 rtl/mptw_arbiter_if.sv | 13 +
 rtl/mptw_rr_pick.sv | 34 +++
 rtl/mptw_arbiter.sv | 117 +++++++++++
 tb/tb_mptw_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mpt_pkg.sv
// Shared types and constants for the page-table-walk request arbiter.
package mpt_pkg;

    localparam int unsigned MAX_OUTSTANDING_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mptw_arbiter_if.sv
// Forwarded-walk channel between the arbiter and the fetch stage slave port.
interface mptw_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ID_W       = 2
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic [ID_W-1:0]       id;

    modport master (output valid, output data, output id, input ready);
    modport slave  (input valid, input data, input id, output ready);
endinterface

// File: rtl/mptw_rr_pick.sv
// Combinational round-robin pick: first valid index at or above ptr, wrapping.
module mptw_rr_pick import mpt_pkg::*; #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    output logic               found_o,
    output logic [ID_W-1:0]    idx_o
);

    logic [NUM_REQ-1:0] shifted;
    int unsigned        pos;

    // Scan NUM_REQ candidate positions starting at ptr; the first hit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        shifted = '0;
        pos     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            shifted = valid_i >> pos;
            if (!found_o && shifted[0]) begin
                found_o = 1'b1;
                idx_o   = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mptw_arbiter.sv
// Round-robin arbiter of page-table-walk requests into one registered
// output entry, with an outstanding-walk limit and pipeline flush.
module mptw_arbiter import mpt_pkg::*; #(
    parameter  int unsigned NUM_REQ         = 4,
    parameter  int unsigned DATA_WIDTH      = 32,
    parameter  int unsigned MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    localparam int unsigned ID_W            = id_width(NUM_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_REQ-1:0]            req_valid_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic                          arb_valid_o,
    input  logic                          arb_ready_i,
    output logic [DATA_WIDTH-1:0]         arb_data_o,
    output logic [ID_W-1:0]               arb_id_o,
    input  logic                          done_i,
    input  logic                          flush_i,
    output logic                          busy_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_e            state_q;
    logic [ID_W-1:0]       ptr_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  pick_found;
    logic [ID_W-1:0]       pick_idx;
    logic                  handshake;
    logic                  entry_free;
    logic                  done_eff;
    logic                  grant;
    logic [DATA_WIDTH-1:0] pick_data;

    mptw_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .valid_i (req_valid_i),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Grant qualification; done_i at cnt 0 is ignored so it cannot open a slot.
    always_comb begin
        handshake   = arb_valid_o && arb_ready_i;
        entry_free  = (state_q == IDLE) || handshake;
        done_eff    = done_i && (cnt_q != '0);
        grant       = rst_ni && entry_free && !flush_i && pick_found &&
                      ((cnt_q - CNT_W'(done_eff)) < CNT_W'(MAX_OUTSTANDING));
        req_ready_o = grant ? (NUM_REQ'(1) << pick_idx) : '0;
        pick_data   = DATA_WIDTH'(req_data_i >> (int'(pick_idx) * DATA_WIDTH));
        busy_o      = arb_valid_o || (cnt_q != '0);
    end

    // Output entry FSM; flush empties the entry regardless of handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            arb_valid_o <= 1'b0;
            arb_data_o  <= '0;
            arb_id_o    <= '0;
        end else if (flush_i) begin
            state_q     <= IDLE;
            arb_valid_o <= 1'b0;
            arb_data_o  <= '0;
            arb_id_o    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        state_q     <= HOLD;
                        arb_valid_o <= 1'b1;
                        arb_data_o  <= pick_data;
                        arb_id_o    <= pick_idx;
                    end
                end
                HOLD: begin
                    if (grant) begin
                        arb_data_o <= pick_data;
                        arb_id_o   <= pick_idx;
                    end else if (handshake) begin
                        state_q     <= IDLE;
                        arb_valid_o <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    arb_valid_o <= 1'b0;
                end
            endcase
        end
    end

    // Outstanding-walk counter and round-robin pointer; flush keeps the pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            ptr_q <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else begin
            if (grant && !done_eff) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!grant && done_eff) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (grant) begin
                ptr_q <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mptw_arbiter.sv
// Directed scoreboard bench for mptw_arbiter with a small reference model.
module tb_mptw_arbiter;

    localparam int unsigned NR   = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned IDW  = 2;
    localparam int unsigned MAXO = 4;

    logic               clk = 1'b0;
    logic               rst_ni;
    logic [NR-1:0]      req_valid;
    logic [NR-1:0]      req_ready;
    logic [NR*DW-1:0]   req_data;
    logic               done;
    logic               flush;
    logic               busy;

    always #5 clk = ~clk;

    mptw_arbiter_if #(.DATA_WIDTH(DW), .ID_W(IDW)) fetch_if ();

    mptw_arbiter #(
        .NUM_REQ         (NR),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_data_i  (req_data),
        .arb_valid_o (fetch_if.valid),
        .arb_ready_i (fetch_if.ready),
        .arb_data_o  (fetch_if.data),
        .arb_id_o    (fetch_if.id),
        .done_i      (done),
        .flush_i     (flush),
        .busy_o      (busy)
    );

    typedef struct {
        logic [DW-1:0]  data;
        logic [IDW-1:0] id;
    } exp_t;

    exp_t          sb[$];
    int            checks    = 0;
    int            failures  = 0;
    int            m_ptr     = 0;
    int            m_cnt     = 0;
    bit            m_valid   = 1'b0;
    int            dut_grants = 0;
    logic [DW-1:0] dword[NR];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = dword[i];
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_cnt   = 0;
        m_valid = 1'b0;
        sb.delete();
    endtask

    // Check one cycle against the model, update the model, advance to next negedge.
    task automatic step(input string tag);
        logic [NR-1:0] exp_ready;
        bit            g;
        bit            de;
        bit            hs;
        int            w;
        #1;
        if (req_ready != '0) dut_grants++;
        if (!rst_ni) begin
            check_eq({tag, "_rst_ready"}, 64'(req_ready), 64'(0));
            check_eq({tag, "_rst_busy"},  64'(busy),      64'(0));
            check_eq({tag, "_rst_valid"}, 64'(fetch_if.valid), 64'(0));
            @(negedge clk);
            return;
        end
        de = done && (m_cnt != 0);
        hs = m_valid && fetch_if.ready;
        g  = 1'b0;
        w  = 0;
        if ((!m_valid || fetch_if.ready) && !flush && ((m_cnt - int'(de)) < MAXO)) begin
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (m_ptr + k) % NR;
                if (!g && req_valid[j]) begin
                    g = 1'b1;
                    w = j;
                end
            end
        end
        exp_ready = g ? (NR'(1) << w) : '0;
        check_eq({tag, "_ready"}, 64'(req_ready), 64'(exp_ready));
        check_eq({tag, "_valid"}, 64'(fetch_if.valid), 64'(m_valid));
        check_eq({tag, "_busy"},  64'(busy), 64'(m_valid || (m_cnt != 0)));
        if (m_valid && sb.size() > 0) begin
            check_eq({tag, "_data"}, 64'(fetch_if.data), 64'(sb[0].data));
            check_eq({tag, "_id"},   64'(fetch_if.id),   64'(sb[0].id));
        end
        if (flush) begin
            m_valid = 1'b0;
            m_cnt   = 0;
            sb.delete();
        end else begin
            if (hs) void'(sb.pop_front());
            if (g) begin
                sb.push_back('{dword[w], IDW'(w)});
                m_valid = 1'b1;
                m_ptr   = (w + 1) % NR;
            end else if (hs) begin
                m_valid = 1'b0;
            end
            m_cnt = m_cnt + int'(g) - int'(de);
        end
        @(negedge clk);
    endtask

    // Empty the entry and retire every outstanding walk.
    task automatic drain();
        req_valid      = '0;
        done           = 1'b1;
        flush          = 1'b0;
        fetch_if.ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (m_cnt == 0 && !m_valid) break;
            step("drain");
        end
        done = 1'b0;
    endtask

    initial begin
        rst_ni         = 1'b0;
        req_valid      = '0;
        req_data       = '0;
        done           = 1'b0;
        flush          = 1'b0;
        fetch_if.ready = 1'b0;
        for (int i = 0; i < NR; i++) dword[i] = '0;
        model_reset();

        // Reset held, requests present: nothing may be granted.
        @(negedge clk);
        req_valid = '1;
        step("reset");
        step("reset");
        rst_ni    = 1'b1;
        req_valid = '0;

        // Spurious done with nothing outstanding.
        done = 1'b1;
        step("spur_done");
        step("spur_done");
        #1 check_eq("spur_busy", 64'(busy), 64'(0));
        done = 1'b0;
        @(negedge clk);

        // Round-robin with all requesters valid, done every cycle.
        req_valid      = '1;
        fetch_if.ready = 1'b1;
        done           = 1'b1;
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < NR; i++) dword[i] = 32'h1000_0000 + 32'(c * 16 + i);
            drive_data();
            step("rr");
        end
        drain();

        // Backpressure on a single requester.
        dword[0]       = 32'hA5A5_0001;
        drive_data();
        req_valid      = 4'b0001;
        fetch_if.ready = 1'b0;
        step("bp_grant");
        for (int c = 0; c < 5; c++) begin
            #1;
            check_eq("bp_hold_data",  64'(fetch_if.data), 64'(32'hA5A5_0001));
            check_eq("bp_hold_ready", 64'(req_ready),     64'(0));
            step("bp_hold");
        end
        fetch_if.ready = 1'b1;
        step("bp_release");
        req_valid = '0;
        step("bp_empty");
        drain();

        // Outstanding limit with no completions.
        dword[1]       = 32'hB0B0_0011;
        drive_data();
        req_valid      = 4'b0010;
        fetch_if.ready = 1'b1;
        done           = 1'b0;
        dut_grants     = 0;
        for (int c = 0; c < 7; c++) step("outst");
        check_eq("outst_grants", 64'(dut_grants), 64'(4));
        dut_grants = 0;
        done       = 1'b1;
        step("outst_done");
        done = 1'b0;
        check_eq("outst_regrant", 64'(dut_grants), 64'(1));
        step("outst_full");
        drain();

        // Flush while holding with three walks outstanding.
        dword[2]       = 32'hC0C0_0022;
        drive_data();
        req_valid      = 4'b0100;
        fetch_if.ready = 1'b1;
        for (int c = 0; c < 3; c++) step("fl_fill");
        fetch_if.ready = 1'b0;
        flush          = 1'b1;
        step("flush");
        flush     = 1'b0;
        req_valid = '0;
        #1;
        check_eq("flush_valid", 64'(fetch_if.valid), 64'(0));
        check_eq("flush_busy",  64'(busy),           64'(0));
        step("post_flush");
        req_valid      = '1;
        fetch_if.ready = 1'b1;
        #1 check_eq("flush_ptr_kept", 64'(req_ready), 64'(4'b1000));
        step("post_flush_rr");

        // Async reset in the middle of a cycle while holding.
        fetch_if.ready = 1'b0;
        req_valid      = '0;
        #2 rst_ni = 1'b0;
        #1;
        check_eq("arst_valid", 64'(fetch_if.valid), 64'(0));
        check_eq("arst_busy",  64'(busy),           64'(0));
        check_eq("arst_ready", 64'(req_ready),      64'(0));
        model_reset();
        @(negedge clk);
        step("arst_hold");
        rst_ni         = 1'b1;
        req_valid      = '1;
        fetch_if.ready = 1'b1;
        #1 check_eq("arst_first", 64'(req_ready), 64'(4'b0001));
        step("arst_first");
        step("arst_next");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
